// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: game-round controller for the whack-a-mole.
// It lights one hole per round, judges the player's button presses, and
// keeps the score, lives and level. It also drives the countdown timer:
// the timer is held in reload during every state except WAIT, so each
// round begins with a fresh interval.
//
// Optional build macro: BONUS_LIFE_EN. When defined, every real level-up
// also grants one life, up to a maximum of 3.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse that starts or restarts a game (honoured in IDLE/OVER)
//   btn[3:0]   in   per-hole hit buttons, debounced single-cycle pulses
//   timeout    in   pulse from the timer when the interval expires
//   timer_rst  out  timer reset/reload, high everywhere except WAIT
//   interval   out  timer interval, max(START_INTERVAL - level, MIN_INTERVAL)
//   dir        out  timer count direction, constant COUNT_UP
//   mole[3:0]  out  one-hot lit hole, 0 when no mole is shown
//   score      out  hits this game, saturates at 255
//   lives      out  remaining lives
//   level      out  current level, saturates at 7
//   game_over  out  high in OVER
//
// state | meaning
// IDLE  | no game yet, waiting for start
// ARM   | timer reloading for one cycle, next hole picked
// WAIT  | mole lit, timer running, judging buttons/timeout
// HIT   | correct hole pressed, score already updated
// MISS  | wrong hole or timeout, life already deducted
// OVER  | out of lives, score/level held for display
module mole_round_ctrl #(
  parameter int START_INTERVAL = 5,
  parameter int MIN_INTERVAL   = 1,
  parameter int HITS_PER_LEVEL = 4,
  parameter int INIT_LIVES     = 3,
  parameter int COUNT_UP       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       timeout,
  output logic       timer_rst,
  output logic [2:0] interval,
  output logic       dir,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       game_over
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_HIT, S_MISS, S_OVER} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lfsr, w_lfsr_nxt;
  logic [1:0] r_prev_hole, w_prev_nxt;
  logic [1:0] w_pick;
  logic [3:0] r_mole, w_mole_nxt;
  logic       r_timer_rst;
  logic       r_game_over;
  logic [2:0] r_interval, w_interval_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic [2:0] r_level, w_level_nxt;
  logic [3:0] r_hits, w_hits_nxt;

  // Galois LFSR, x^8+x^6+x^5+x^4+1, shifting right.
  assign w_lfsr_nxt = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);

  // Never repeat the previous hole: bump a collision to the next hole.
  assign w_pick = (r_lfsr[1:0] == r_prev_hole) ? r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev_hole;
    w_score_nxt = r_score;
    w_lives_nxt = r_lives;
    w_level_nxt = r_level;
    w_hits_nxt  = r_hits;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_score_nxt = 8'd0;
          w_lives_nxt = 2'(INIT_LIVES);
          w_level_nxt = 3'd0;
          w_hits_nxt  = 4'd0;
        end
      end
      S_ARM: begin
        w_state_nxt = S_WAIT;
        w_prev_nxt  = w_pick;
      end
      S_WAIT: begin
        // Score/lives update on entry to HIT/MISS so they are visible there.
        if (btn[r_prev_hole]) begin
          w_state_nxt = S_HIT;
          if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
          if (r_hits == 4'(HITS_PER_LEVEL - 1)) begin
            w_hits_nxt = 4'd0;
            if (r_level != 3'd7) begin
              w_level_nxt = r_level + 3'd1;
`ifdef BONUS_LIFE_EN
              if (r_lives != 2'd3) w_lives_nxt = r_lives + 2'd1;
`endif
            end
          end else begin
            w_hits_nxt = r_hits + 4'd1;
          end
        end else if ((btn != 4'd0) || timeout) begin
          w_state_nxt = S_MISS;
          w_lives_nxt = r_lives - 2'd1;
        end
      end
      S_HIT:   w_state_nxt = S_ARM;
      S_MISS:  w_state_nxt = (r_lives == 2'd0) ? S_OVER : S_ARM;
      default: w_state_nxt = S_IDLE;
    endcase

    w_mole_nxt = (w_state_nxt == S_WAIT) ? (4'b0001 << w_prev_nxt) : 4'd0;

    if (({1'b0, w_level_nxt} + 4'(MIN_INTERVAL)) >= 4'(START_INTERVAL))
      w_interval_nxt = 3'(MIN_INTERVAL);
    else
      w_interval_nxt = 3'(START_INTERVAL) - w_level_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 8'hA5;
      r_prev_hole <= 2'd0;
      r_mole      <= 4'd0;
      r_timer_rst <= 1'b1;
      r_game_over <= 1'b0;
      r_interval  <= 3'(START_INTERVAL);
      r_score     <= 8'd0;
      r_lives     <= 2'(INIT_LIVES);
      r_level     <= 3'd0;
      r_hits      <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_prev_hole <= w_prev_nxt;
      r_mole      <= w_mole_nxt;
      r_timer_rst <= (w_state_nxt != S_WAIT);
      r_game_over <= (w_state_nxt == S_OVER);
      r_interval  <= w_interval_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_level     <= w_level_nxt;
      r_hits      <= w_hits_nxt;
    end
  end

  assign timer_rst = r_timer_rst;
  assign interval  = r_interval;
  assign dir       = 1'(COUNT_UP);
  assign mole      = r_mole;
  assign score     = r_score;
  assign lives     = r_lives;
  assign level     = r_level;
  assign game_over = r_game_over;

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Game-round controller for the whack-a-mole, directly downstream of the countdown timer/7-seg stage.
- Consumes the timer's `timeout` pulse.
- Drives the timer's `reset_signal`, `interval` and `dir` inputs.
- Picks a pseudo-random lit hole, judges button hits, and keeps score, lives and level.

Parameters:
- START_INTERVAL, 5, timer interval (seconds) at level 0; range 1..7.
- MIN_INTERVAL, 1, floor for interval as level rises; must be ≤ START_INTERVAL.
- HITS_PER_LEVEL, 4, consecutive-or-not hits needed to advance one level; 1..15.
- INIT_LIVES, 3, lives loaded at game start; 1..3.
- COUNT_UP, 0, value driven on `dir` (0 = timer counts down from interval to 0).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse, begins/restarts a game.
- btn  in  4  per-hole hit buttons, already debounced, single-cycle pulses.
- timeout  in  1  single-cycle pulse from timer when interval expires.
- timer_rst  out  1  to timer `reset_signal`; high holds/reloads timer.
- interval  out  3  to timer `interval`.
- dir  out  1  to timer `dir`; constant COUNT_UP.
- mole  out  4  one-hot lit hole; 0 when no mole shown.
- score  out  8  hits this game, saturates at 255.
- lives  out  2  remaining lives.
- level  out  3  current level, saturates at 7.
- game_over  out  1  high in OVER state.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs and state are registered.
- Reset values:
  - state=IDLE, timer_rst=1, interval=START_INTERVAL, mole=0, score=0.
  - lives=INIT_LIVES, level=0, game_over=0, hit counter=0.
  - lfsr=8'hA5, prev_hole=0.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle in every state, so hole choice depends on player timing.
  - Never all-zero.
- Hole pick (in ARM):
  - cand = lfsr[1:0].
  - If cand == prev_hole, hole = cand+1 mod 4; else hole = cand.
  - prev_hole <= hole.
- interval = max(START_INTERVAL − level, MIN_INTERVAL). Updated the cycle after level changes.
- IDLE:
  - timer_rst=1, mole=0.
  - start → ARM. Score, lives and level are cleared/loaded as at reset.
- ARM (exactly 1 cycle):
  - timer_rst=1; picks hole.
  - → WAIT next cycle.
  - Timer is therefore reloaded with the current interval for ≥1 cycle before each round.
- WAIT:
  - timer_rst=0, mole=onehot(hole).
  - btn[hole]=1 → HIT. This takes priority over timeout and over other btn bits in the same cycle.
  - Any btn bit other than hole, with btn[hole]=0 → MISS.
  - timeout=1 with no btn → MISS.
  - Otherwise stay.
- HIT (1 cycle):
  - mole=0, timer_rst=1.
  - score+1 (sat 255) and hit counter+1.
  - If the counter reaches HITS_PER_LEVEL: counter=0, level+1 (sat 7).
  - → ARM.
- MISS (1 cycle):
  - mole=0, timer_rst=1, lives−1.
  - If lives was 1 → OVER; else → ARM.
- OVER:
  - game_over=1, mole=0, timer_rst=1.
  - score and level hold for display.
  - start → reload as IDLE start → ARM.
- start in any state other than IDLE/OVER: ignored.
- btn and timeout in states other than WAIT: ignored (no queuing).
- rst_n asserted mid-round: immediate return to reset values; mole goes dark asynchronously.

Optional Feature:
- Macro: BONUS_LIFE_EN.
- Defined: each level increment also grants lives+1, saturating at 3. Only when level actually increments (not at level 7 saturation).
- Undefined: lives only decrease; level-up has no effect on lives.

Test Plan:
- Reset, then start pulse → timer_rst high 1 cycle (ARM), then mole = one-hot of lfsr-derived hole, timer_rst=0, interval=5, lives=3, score=0.
- In WAIT, pulse btn matching mole → next cycle HIT: mole=0, score=1; 1 cycle later timer_rst=1 (ARM); new mole ≠ previous mole.
- Four hits → level=1, interval=4. Continue to level 4+ → interval floors at 1. Without BONUS_LIFE_EN lives stays 3; with it, lives stays at 3 (saturated) after losing one then levelling.
- Same cycle: timeout=1 and btn[hole]=1 → HIT (score+1, lives unchanged). Wrong btn alone → MISS, lives−1.
- Three timeouts with no presses → lives 3→2→1→0, game_over=1, mole=0, timer_rst=1. Later btn/timeout pulses → no change. start → lives=3, score=0, level=0, ARM.
- Assert rst_n low during WAIT → mole=0, timer_rst=1, state IDLE immediately. Score at 255 plus a hit → stays 255.
